// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: FSM state encoding and its width.
package pll_sup_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    StPllRst   = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset to zero.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      sync_q  <= '0;
    end else begin
      stage_q <= d;
      sync_q  <= stage_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock qualification and core reset release; counts loss-of-lock
// events and latches a sticky failure after repeated lock timeouts.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT   = 50000,
  parameter int unsigned STABLE_CYCLES  = 1024,
  parameter int unsigned LOL_FILTER     = 4,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned CNT_W          = 17
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               locked,
  input  logic               retry_req,
  output logic               pll_rst,
  output logic               core_reset_n,
  output logic               fail,
  output logic [STATE_W-1:0] state,
  output logic [7:0]         lol_count
);

  localparam logic [CNT_W-1:0] RstLast     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LolLast     = CNT_W'(LOL_FILTER - 1);
  localparam logic [7:0]       MaxRetries  = 8'(MAX_RETRIES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       retries_q, retries_d, retries_inc;
  logic [7:0]       lol_q, lol_d;
  logic             pll_rst_q, pll_rst_d;
  logic             core_q, core_d;
  logic             fail_q, fail_d;
  logic             lk_s;

  sync_2ff #(
    .WIDTH (1)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (locked),
    .q     (lk_s)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    retries_d   = retries_q;
    lol_d       = lol_q;
    retries_inc = retries_q + 8'd1;

    case (state_q)
      StPllRst: begin
        if (cnt_q == RstLast) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StWaitLock: begin
        // Lock is checked first so a lock arriving on the timeout cycle wins.
        if (lk_s) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == TimeoutLast) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == MaxRetries) ? StFail : StPllRst;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StStable: begin
        if (!lk_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == StableLast) begin
          state_d   = StRun;
          retries_d = '0;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StRun: begin
        // The shared counter doubles as the consecutive-low filter while running.
        if (lk_s) begin
          cnt_d = '0;
        end else if (cnt_q == LolLast) begin
          state_d = StPllRst;
          cnt_d   = '0;
          lol_d   = (lol_q == 8'hFF) ? lol_q : lol_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StFail: begin
        if (retry_req) begin
          state_d   = StPllRst;
          retries_d = '0;
          cnt_d     = '0;
        end
      end
      default: begin
        state_d = StPllRst;
        cnt_d   = '0;
      end
    endcase

    pll_rst_d = (state_d == StPllRst) || (state_d == StFail);
    // Release one cycle after entering RUN, but drop on the edge that leaves it.
    core_d    = (state_q == StRun) && (state_d == StRun);
    fail_d    = (state_d == StFail);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StPllRst;
      cnt_q     <= '0;
      retries_q <= '0;
      lol_q     <= '0;
      pll_rst_q <= 1'b1;
      core_q    <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      lol_q     <= lol_d;
      pll_rst_q <= pll_rst_d;
      core_q    <= core_d;
      fail_q    <= fail_d;
    end
  end

  assign state        = state_q;
  assign pll_rst      = pll_rst_q;
  assign core_reset_n = core_q;
  assign fail         = fail_q;
  assign lol_count    = lol_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench: per-cycle vector table for bring-up, filtering, timeout and retry,
// plus sequences for lol_count saturation and asynchronous reset in RUN.
module tb_pll_lock_supervisor;

  logic       clk;
  logic       reset_n;
  logic       locked;
  logic       retry_req;
  logic       pll_rst;
  logic       core_reset_n;
  logic       fail;
  logic [2:0] state;
  logic [7:0] lol_count;

  int checks = 0;
  int errors = 0;

  pll_lock_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (20),
    .STABLE_CYCLES  (8),
    .LOL_FILTER     (3),
    .MAX_RETRIES    (2),
    .CNT_W          (17)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .locked       (locked),
    .retry_req    (retry_req),
    .pll_rst      (pll_rst),
    .core_reset_n (core_reset_n),
    .fail         (fail),
    .state        (state),
    .lol_count    (lol_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each record: hold inputs for n edges, outputs must match after every one of them.
  typedef struct {
    int         n;
    logic       rst_n;
    logic       lk;
    logic       rr;
    logic [2:0] st;
    logic       pr;
    logic       cn;
    logic       fl;
    logic [7:0] lol;
  } vec_t;

  localparam int NumVec = 26;
  vec_t vecs [NumVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_state(input string name, input logic [2:0] s, input int max_cycles);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < max_cycles && !ok; c++) begin
      @(posedge clk);
      #1;
      if (state == s) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: state %0d not reached within %0d cycles, now %0d",
               name, s, max_cycles, state);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] lol_exp;

    // n, rst_n, locked, retry_req | state, pll_rst, core_reset_n, fail, lol_count
    vecs[0]  = '{1,  1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0}; // held in reset
    vecs[1]  = '{3,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd0}; // pll_rst cycles
    vecs[2]  = '{6,  1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{2,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd0}; // sync latency
    vecs[4]  = '{8,  1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'd0}; // RUN, core still 0
    vecs[6]  = '{5,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{2,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0}; // 2-cycle glitch
    vecs[8]  = '{6,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{4,  1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd0}; // real loss
    vecs[10] = '{4,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[11] = '{20, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1}; // timeout 1
    vecs[12] = '{4,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[13] = '{20, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1}; // timeout 2
    vecs[14] = '{3,  1'b1, 1'b0, 1'b0, 3'd4, 1'b1, 1'b0, 1'b1, 8'd1}; // sticky FAIL
    vecs[15] = '{1,  1'b1, 1'b0, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1}; // retry_req
    vecs[16] = '{3,  1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 8'd1};
    vecs[17] = '{2,  1'b1, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1}; // retry ignored
    vecs[18] = '{2,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[19] = '{4,  1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[20] = '{1,  1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd1}; // 1-cycle glitch
    vecs[21] = '{1,  1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[22] = '{1,  1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[23] = '{8,  1'b1, 1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 1'b0, 8'd1}; // full restart
    vecs[24] = '{1,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[25] = '{2,  1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 8'd1};

    reset_n   = 1'b0;
    locked    = 1'b0;
    retry_req = 1'b0;

    for (int i = 0; i < NumVec; i++) begin
      for (int k = 0; k < vecs[i].n; k++) begin
        reset_n   = vecs[i].rst_n;
        locked    = vecs[i].lk;
        retry_req = vecs[i].rr;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d.%0d state", i, k), 32'(state), 32'(vecs[i].st));
        chk($sformatf("v%0d.%0d pll_rst", i, k), 32'(pll_rst), 32'(vecs[i].pr));
        chk($sformatf("v%0d.%0d core_reset_n", i, k), 32'(core_reset_n), 32'(vecs[i].cn));
        chk($sformatf("v%0d.%0d fail", i, k), 32'(fail), 32'(vecs[i].fl));
        chk($sformatf("v%0d.%0d lol_count", i, k), 32'(lol_count), 32'(vecs[i].lol));
      end
    end
    retry_req = 1'b0;

    // Repeated loss-of-lock events: the count must saturate at 255.
    lol_exp = 8'd1;
    for (int e = 0; e < 260; e++) begin
      locked = 1'b0;
      wait_state($sformatf("lol%0d enter PLL_RST", e), 3'd0, 10);
      lol_exp = (lol_exp == 8'hFF) ? lol_exp : lol_exp + 8'd1;
      chk($sformatf("lol%0d lol_count", e), 32'(lol_count), 32'(lol_exp));
      locked = 1'b1;
      wait_state($sformatf("lol%0d relock RUN", e), 3'd3, 60);
    end
    chk("sat lol_count", 32'(lol_count), 32'd255);
    @(posedge clk);
    #1;
    chk("sat core_reset_n", 32'(core_reset_n), 32'd1);

    // Asynchronous reset mid-cycle while running.
    #2;
    reset_n = 1'b0;
    #1;
    chk("async pll_rst", 32'(pll_rst), 32'd1);
    chk("async core_reset_n", 32'(core_reset_n), 32'd0);
    chk("async lol_count", 32'(lol_count), 32'd0);
    chk("async state", 32'(state), 32'd0);
    chk("async fail", 32'(fail), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    wait_state("post-reset WAIT_LOCK", 3'd1, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Supervises the core PLL from the free-running 50 MHz reference clock.
- Drives the PLL reset, waits for a stable lock, then releases the core-domain reset request.
- On loss of lock it re-resets the PLL and counts the event. After repeated lock timeouts it enters a sticky fail state.
- Sits between the board reset, the PLL wrapper (`rst`/`locked`) and the core reset synchronizer.

Parameters:
- PLL_RST_CYCLES, 16, cycles pll_rst is held high per attempt (>=1)
- LOCK_TIMEOUT, 50000, cycles allowed for locked to rise per attempt (1 ms at 50 MHz)
- STABLE_CYCLES, 1024, consecutive synced-locked-high cycles required before core release
- LOL_FILTER, 4, consecutive synced-locked-low cycles in RUN that count as loss of lock
- MAX_RETRIES, 3, timed-out attempts allowed before FAIL
- CNT_W, 17, width of the shared cycle counter (must hold the largest of the cycle parameters)

Ports:
- clk  in  1  reference clock (PLL refclk, free-running)
- reset_n  in  1  asynchronous active-low reset
- locked  in  1  PLL locked, asynchronous to clk
- retry_req  in  1  single-cycle pulse: leave FAIL and restart the sequence
- pll_rst  out  1  active-high reset to the PLL
- core_reset_n  out  1  active-low reset request to the core domain
- fail  out  1  sticky failure flag
- state  out  3  encoded FSM state, for status/debug
- lol_count  out  8  saturating count of loss-of-lock events

Behaviour:
- locked passes through a 2-FF synchronizer (lk_s) reset to 0. All decisions use lk_s, which lags locked by 2 cycles.
- Reset (async assert, sync release): state=PLL_RST, pll_rst=1, core_reset_n=0, fail=0, lol_count=0, counter=0, retry count=0.
- States and encodings: PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4.
- PLL_RST:
  - pll_rst=1, core_reset_n=0.
  - Counter runs 0..PLL_RST_CYCLES-1, then go to WAIT_LOCK with counter cleared.
  - pll_rst is high for exactly PLL_RST_CYCLES clocks.
- WAIT_LOCK:
  - pll_rst=0.
  - If lk_s=1, go to STABLE with counter cleared.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, increment retries.
  - If the new retries equals MAX_RETRIES, go to FAIL; else go to PLL_RST.
  - If lk_s rises on the timeout cycle, lock wins.
- STABLE:
  - If lk_s=0, go to WAIT_LOCK with counter cleared. Retries are not incremented and the timeout restarts.
  - When the counter reaches STABLE_CYCLES-1 with lk_s=1, go to RUN and clear retries.
- RUN:
  - core_reset_n=1 (registered; rises on the cycle after entering RUN).
  - A filter counter counts consecutive lk_s=0 cycles and clears on any lk_s=1.
  - When it reaches LOL_FILTER, increment lol_count (saturating at 255), go to PLL_RST, and drop core_reset_n on the same edge.
  - Glitches shorter than LOL_FILTER cycles are ignored.
- FAIL:
  - pll_rst=1, core_reset_n=0, fail=1.
  - A retry_req pulse clears fail and retries and goes to PLL_RST.
  - retry_req is ignored in all other states.
- core_reset_n is 1 only in RUN. pll_rst is 1 only in PLL_RST and FAIL. All outputs are registered.
- Illegal state encoding: recover to PLL_RST.
- reset_n asserted mid-operation: immediate return to reset values. lol_count is cleared as well.

Decomposition:
- Shared package pll_sup_pkg: state enum (3-bit encodings above) and STATE_W=3.
- Natural sub-module: sync_2ff (generic 2-flop synchronizer with async active-low reset), reusable for the core-domain reset release.

Test Plan:
Each scenario uses PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, LOL_FILTER=3, MAX_RETRIES=2.
- Normal bring-up: release reset_n, raise locked at cycle 10 -> pll_rst high cycles 0-3; state path 0->1->2->3; core_reset_n=1 about 10 cycles after lk_s rises.
- Lock glitch in STABLE: drop locked for 1 cycle after 4 stable cycles -> return to WAIT_LOCK; retries unchanged; full 8-cycle stable count restarts.
- RUN glitch filter: locked low 2 cycles -> stays RUN, lol_count=0. Locked low 3 cycles -> PLL_RST, core_reset_n=0, lol_count=1.
- Timeout and fail: locked held 0 -> two 4+20-cycle attempts, then FAIL with fail=1, pll_rst=1. Pulse retry_req -> fail=0, PLL_RST, sequence restarts.
- Saturation: force 260 loss-of-lock events -> lol_count stays 255.
- Async reset in RUN: assert reset_n mid-cycle -> pll_rst=1 and core_reset_n=0 immediately (before next edge); lol_count=0.
